// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver: latches hex data, scans one digit per DIV clocks,
// decodes to active-low gfedcba with leading-zero blanking, decimal points, blink and a frame pulse.
module seg7_scan #(
  parameter int DIGITS    = 4,
  parameter int DIV       = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                LOAD,
  input  logic [DIGITS*4-1:0] DATA,
  input  logic [DIGITS-1:0]   DP_IN,
  input  logic                LZB,
  input  logic                BLINK,
  output logic [6:0]          SEG,
  output logic                DP,
  output logic [DIGITS-1:0]   AN,
  output logic                FRAME
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIGITS*4-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                phase;
  logic [DIGITS-1:0]   lz;
  logic                slot_end;
  logic                last_digit;
  logic                wrap;
  logic [3:0]          nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h58;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign slot_end   = (cnt == CW'(DIV - 1));
  assign last_digit = (idx == IW'(DIGITS - 1));
  assign wrap       = EN && slot_end && last_digit;
  assign nib        = data_q[4*idx +: 4];

  // lz[i] is set when every nibble from the top down to i is zero; digit 0 never qualifies.
  always_comb begin
    logic zero_above;
    lz = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (data_q[4*i +: 4] == 4'h0);
      lz[i] = zero_above;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
      dp_q   <= '0;
    end else if (LOAD) begin
      data_q <= DATA;
      dp_q   <= DP_IN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else if (EN) begin
      if (slot_end) begin
        cnt <= '0;
        idx <= last_digit ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (!BLINK) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      if (fcnt == FW'(BLINK_DIV - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEG   <= 7'h7F;
      DP    <= 1'b1;
      AN    <= '1;
      FRAME <= 1'b0;
    end else begin
      FRAME <= wrap;
      if (!EN || (BLINK && phase)) begin
        SEG <= 7'h7F;
        DP  <= 1'b1;
        AN  <= '1;
      end else begin
        AN  <= ~(DIGITS'(1) << idx);
        SEG <= (LZB && lz[idx]) ? 7'h7F : decode(nib);
        DP  <= ~dp_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised scoreboard bench for seg7_scan: an arithmetic scan-position model predicts each cycle's outputs.
module tb_seg7_scan;
  localparam int DIGITS    = 4;
  localparam int DIV       = 4;
  localparam int BLINK_DIV = 2;
  localparam logic [12:0] RST_OUT = {7'h7F, 1'b1, 4'hF, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        lzb = 1'b0;
  logic        blink = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int total = 0;
  int passed = 0;

  logic [12:0] exp_q[$];
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .CLK(clk), .RST(rst), .EN(en), .LOAD(load), .DATA(data), .DP_IN(dp_in),
    .LZB(lzb), .BLINK(blink), .SEG(seg), .DP(dp), .AN(an), .FRAME(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s t=%0t got seg=%h dp=%b an=%b frame=%b, want seg=%h dp=%b an=%b frame=%b",
                  name, $time, got[12:6], got[5], got[4:1], got[0],
                  want[12:6], want[5], want[4:1], want[0]);
  endtask

  // Reference model: scan position is just the number of enabled clocks since reset.
  int          pos;
  int          bframes;
  logic [15:0] m_data;
  logic [3:0]  m_dp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos = 0;
      bframes = 0;
      m_data = '0;
      m_dp = '0;
      exp_q.delete();
    end else begin
      int d;
      bit w;
      bit ph;
      logic [12:0] e;
      logic [3:0] sel;
      logic [6:0] s;
      d  = (pos / DIV) % DIGITS;
      w  = en && ((pos % (DIV * DIGITS)) == DIV * DIGITS - 1);
      ph = ((bframes / BLINK_DIV) % 2) == 1;
      if (!en || (blink && ph)) begin
        e = {7'h7F, 1'b1, 4'hF, w};
      end else begin
        sel = 4'b0001 << d;
        if (lzb && d >= 1 && (m_data >> (4 * d)) == 16'h0) s = 7'h7F;
        else s = seg_tab[(m_data >> (4 * d)) & 16'hF];
        e = {s, ~m_dp[d], ~sel, w};
      end
      exp_q.push_back(e);
      if (en) pos++;
      if (!blink) bframes = 0;
      else if (w) bframes++;
      if (load) begin
        m_data = data;
        m_dp = dp_in;
      end
    end
  end

  always @(negedge clk) begin
    if (rst || exp_q.size() == 0) chk("idle_reset", {seg, dp, an, frame}, RST_OUT);
    else chk("scan", {seg, dp, an, frame}, exp_q.pop_front());
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    data = v;
    dp_in = p;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {seg, dp, an, frame}, RST_OUT);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    en = 1'b1;
    do_load(16'h00A7, 4'b0000);
    cyc(40);
    lzb = 1'b1;
    cyc(40);
    do_load(16'h0000, 4'b0000);
    cyc(40);
    do_load(16'hFEDC, 4'b0101);
    cyc(40);
    blink = 1'b1;
    cyc(150);
    blink = 1'b0;
    cyc(21);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(30);
    async_reset();
    cyc(20);
    do_load(16'h1234, 4'b1000);
    cyc(20);
    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom % 8) == 0;
      data  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      dp_in = 4'($urandom);
      en    = ($urandom % 16) != 0;
      if ($urandom % 50 == 0) lzb = ~lzb;
      if ($urandom % 80 == 0) blink = ~blink;
      if ($urandom % 700 == 0) async_reset();
      else cyc(1);
    end
    load = 1'b0;
    cyc(5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
